// File: rtl/rr_mux4_arbiter_if.sv
// Bundle for the round-robin mux arbiter: four requests, four 4-bit data
// channels, and the registered grant/select/data outputs.
interface rr_mux4_arbiter_if;
    logic [3:0] req;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] c;
    logic [3:0] d;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic [3:0] f;
    logic       f_valid;

    modport master (
        output req, a, b, c, d,
        input  gnt, sel, busy, f, f_valid
    );

    modport slave (
        input  req, a, b, c, d,
        output gnt, sel, busy, f, f_valid
    );
endinterface

// File: rtl/rr_mux4_arbiter.sv
// Round-robin arbiter owning the select of a shared 4:1 4-bit mux; grants one
// requester at a time for at most MAX_HOLD cycles and registers its word onto f.
module rr_mux4_arbiter #(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst,
    rr_mux4_arbiter_if.slave bus
);
    localparam logic [3:0] HOLD = 4'(MAX_HOLD);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t     state_reg,   state_next;
    logic [1:0] ptr_reg,     ptr_next;
    logic [3:0] cnt_reg,     cnt_next;
    logic [3:0] gnt_reg,     gnt_next;
    logic [1:0] sel_reg,     sel_next;
    logic [3:0] f_reg,       f_next;
    logic       f_valid_reg, f_valid_next;

    logic [3:0] others;
    logic [3:0] search_req;
    logic [1:0] search_start;
    logic [3:0] rot;
    logic [1:0] offset;
    logic [1:0] winner;
    logic       release_c;
    logic       word_c;
    logic [3:0] mux_out;

    // Competing requesters exclude the current owner, so an expired owner
    // can only win again when nobody else is waiting.
    assign others       = bus.req & ~gnt_reg;
    assign search_req   = (state_reg == IDLE) ? bus.req : others;
    assign search_start = (state_reg == IDLE) ? ptr_reg : sel_reg + 2'd1;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_rot
            assign rot[gi] = search_req[search_start + 2'(gi)];
        end
    endgenerate

    always_comb begin
        offset = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (rot[i]) offset = 2'(i);
        end
    end

    assign winner    = search_start + offset;
    assign release_c = !bus.req[sel_reg] || ((cnt_reg == HOLD) && (|others));

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        cnt_next   = cnt_reg;
        gnt_next   = gnt_reg;
        sel_next   = sel_reg;
        case (state_reg)
            IDLE: begin
                if (|bus.req) begin
                    state_next = GRANT;
                    gnt_next   = 4'b0001 << winner;
                    sel_next   = winner;
                    cnt_next   = 4'd1;
                end
            end
            GRANT: begin
                if (release_c) begin
                    ptr_next = sel_reg + 2'd1;
                    if (|others) begin
                        gnt_next = 4'b0001 << winner;
                        sel_next = winner;
                        cnt_next = 4'd1;
                    end else begin
                        state_next = IDLE;
                        gnt_next   = 4'b0000;
                    end
                end else if (cnt_reg < HOLD) begin
                    cnt_next = cnt_reg + 4'd1;
                end else begin
                    cnt_next = 4'd1;
                end
            end
            default: begin
                state_next = IDLE;
                gnt_next   = 4'b0000;
            end
        endcase
    end

    always_comb begin
        mux_out = bus.a;
        case (sel_reg)
            2'd0:    mux_out = bus.a;
            2'd1:    mux_out = bus.b;
            2'd2:    mux_out = bus.c;
            default: mux_out = bus.d;
        endcase
    end

    // A word moves only when the owner still requests on this edge.
    assign word_c       = |(gnt_reg & bus.req);
    assign f_next       = word_c ? mux_out : f_reg;
    assign f_valid_next = word_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            ptr_reg     <= 2'd0;
            cnt_reg     <= 4'd0;
            gnt_reg     <= 4'b0000;
            sel_reg     <= 2'd0;
            f_reg       <= 4'd0;
            f_valid_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            ptr_reg     <= ptr_next;
            cnt_reg     <= cnt_next;
            gnt_reg     <= gnt_next;
            sel_reg     <= sel_next;
            f_reg       <= f_next;
            f_valid_reg <= f_valid_next;
        end
    end

    assign bus.gnt     = gnt_reg;
    assign bus.sel     = sel_reg;
    assign bus.busy    = |gnt_reg;
    assign bus.f       = f_reg;
    assign bus.f_valid = f_valid_reg;
endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// Directed bench: two arbiters (MAX_HOLD=4 and MAX_HOLD=2) share data and reset;
// a negedge monitor checks every transferred word against expected queues.
module tb_rr_mux4_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [3:0] req4 = 4'd0;
    logic [3:0] req2 = 4'd0;
    logic [3:0] da = 4'd0, db = 4'd0, dc = 4'd0, dd = 4'd0;

    int n_vec = 0;
    int n_bad = 0;
    logic [3:0] q4[$];
    logic [3:0] q2[$];

    rr_mux4_arbiter_if if4 ();
    rr_mux4_arbiter_if if2 ();

    assign if4.req = req4;
    assign if4.a = da;
    assign if4.b = db;
    assign if4.c = dc;
    assign if4.d = dd;
    assign if2.req = req2;
    assign if2.a = da;
    assign if2.b = db;
    assign if2.c = dc;
    assign if2.d = dd;

    rr_mux4_arbiter #(.MAX_HOLD(4)) u_dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
    rr_mux4_arbiter #(.MAX_HOLD(2)) u_dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

    always #5 clk = ~clk;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            $display("ok   %s: %0h at %0t", name, act, $time);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every f_valid pops the next expected word.
    always @(negedge clk) begin
        if (if4.f_valid) begin
            if (q4.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL sb4_word: got unexpected word %0h at %0t", if4.f, $time);
            end else begin
                check("sb4_word", 32'(if4.f), 32'(q4.pop_front()));
            end
        end
        if (if2.f_valid) begin
            if (q2.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL sb2_word: got unexpected word %0h at %0t", if2.f, $time);
            end else begin
                check("sb2_word", 32'(if2.f), 32'(q2.pop_front()));
            end
        end
    end

    initial begin
        logic [3:0] exp_gnt2 [9];
        exp_gnt2 = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100,
                     4'b0100, 4'b1000, 4'b1000, 4'b0001};

        // Reset state
        tick();
        tick();
        check("rst_gnt", if4.gnt, 4'b0000);
        check("rst_sel", if4.sel, 2'd0);
        check("rst_busy", if4.busy, 1'b0);
        check("rst_f", if4.f, 4'd0);
        check("rst_fvalid", if4.f_valid, 1'b0);
        rst = 1'b0;

        // Single requester on channel 2, hold counter wraps without release
        req4 = 4'b0100;
        dc = 4'hA;
        repeat (5) q4.push_back(4'hA);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("single_gnt", if4.gnt, 4'b0100);
            check("single_sel", if4.sel, 2'd2);
            if (i == 0) check("single_first_fvalid", if4.f_valid, 1'b0);
        end
        req4 = 4'b0000;
        tick();
        check("idle_gnt", if4.gnt, 4'b0000);
        check("idle_busy", if4.busy, 1'b0);
        check("idle_sel_hold", if4.sel, 2'd2);
        check("idle_f_hold", if4.f, 4'hA);
        check("idle_fvalid", if4.f_valid, 1'b0);

        // Early release: 1 -> 3 with no word on the dropping cycle
        req4 = 4'b0010;
        db = 4'h5;
        tick();
        check("early_gnt1", if4.gnt, 4'b0010);
        check("early_sel1", if4.sel, 2'd1);
        req4 = 4'b1000;
        dd = 4'h7;
        tick();
        check("early_gnt3", if4.gnt, 4'b1000);
        check("early_sel3", if4.sel, 2'd3);
        check("early_fvalid", if4.f_valid, 1'b0);
        q4.push_back(4'h7);
        tick();
        check("early_word_valid", if4.f_valid, 1'b1);

        // Pointer rotation: after 3 releases, 0 beats 1
        req4 = 4'b0011;
        da = 4'h1;
        db = 4'h2;
        tick();
        check("rot_gnt", if4.gnt, 4'b0001);
        check("rot_sel", if4.sel, 2'd0);
        check("rot_fvalid", if4.f_valid, 1'b0);
        q4.push_back(4'h1);
        tick();
        check("rot_gnt_hold", if4.gnt, 4'b0001);
        req4 = 4'b0000;
        tick();
        check("rot_idle_gnt", if4.gnt, 4'b0000);
        check("rot_idle_f", if4.f, 4'h1);

        // Fairness with MAX_HOLD=2 on the second arbiter
        da = 4'h1;
        db = 4'h2;
        dc = 4'h3;
        dd = 4'h4;
        req2 = 4'b1111;
        for (int i = 1; i <= 4; i++) begin
            q2.push_back(4'(i));
            q2.push_back(4'(i));
        end
        for (int i = 0; i < 9; i++) begin
            tick();
            check("fair_gnt", if2.gnt, exp_gnt2[i]);
            if (i > 0) check("fair_fvalid", if2.f_valid, 1'b1);
        end
        req2 = 4'b0000;
        tick();
        check("fair_idle_gnt", if2.gnt, 4'b0000);

        // Asynchronous reset during a grant of channel 2
        req4 = 4'b0100;
        dc = 4'h9;
        tick();
        check("mid_gnt", if4.gnt, 4'b0100);
        q4.push_back(4'h9);
        tick();
        check("mid_fvalid", if4.f_valid, 1'b1);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("async_gnt", if4.gnt, 4'b0000);
        check("async_sel", if4.sel, 2'd0);
        check("async_busy", if4.busy, 1'b0);
        check("async_f", if4.f, 4'd0);
        check("async_fvalid", if4.f_valid, 1'b0);
        tick();
        rst = 1'b0;
        req4 = 4'b1111;
        tick();
        check("post_rst_gnt", if4.gnt, 4'b0001);
        req4 = 4'b0000;
        tick();
        check("post_rst_idle", if4.gnt, 4'b0000);

        tick();
        tick();
        check("sb4_drained", q4.size(), 0);
        check("sb2_drained", q2.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
